verificador_secuencia: RTL

Playback-and-check end of the memory game. Once the sequence generator signals its nine-digit store is full, this block reads the stored digits back through the generator's `readAdd`/`outMem` read port. It shows the player a growing prefix of the sequence one digit at a time, then checks the player's key entries against the same prefix. It reports win or error to the top-level game controller and the display.

---
 rtl/memoria_pkg.sv | 24 ++
 rtl/verificador_secuencia_temporizador.sv | 26 ++
 rtl/verificador_secuencia.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/memoria_pkg.sv
// Shared types and constants for the memory-game blocks (sequence store and checker).
package memoria_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned N_DIGITS_DEF = 9;
    localparam int unsigned DIGIT_MIN    = 1;
    localparam int unsigned DIGIT_MAX    = 9;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MEM,
        SHOW,
        GAP,
        INPUT,
        WIN,
        LOSE
    } verif_state_t;

    // The store only ever holds 1..9, so anything outside that range can never match.
    function automatic logic esDigito(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(DIGIT_MIN)) && (d <= DIGIT_W'(DIGIT_MAX));
    endfunction

endpackage

// File: rtl/verificador_secuencia_temporizador.sv
// Loadable down-counter that stops at zero; shared by the show, gap and key-timeout intervals.
module temporizador #(
    parameter int unsigned ANCHO = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld,
    input  logic [ANCHO-1:0] val,
    output logic             cero
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (ld) begin
            cuenta <= val;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - ANCHO'(1);
        end
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/verificador_secuencia.sv
// Plays back a growing prefix of the stored sequence and checks the player's keys against it.
// Optional per-key timeout is enabled by defining VERIF_TIMEOUT_EN.
module verificador_secuencia
    import memoria_pkg::*;
#(
    parameter int unsigned N_DIGITS       = N_DIGITS_DEF,
    parameter int unsigned SHOW_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               memReady,
    output logic [DIGIT_W-1:0] readAdd,
    input  logic [DIGIT_W-1:0] outMem,
    input  logic [DIGIT_W-1:0] key,
    input  logic               keyValid,
    output logic [DIGIT_W-1:0] showDigit,
    output logic               showEn,
    output logic [DIGIT_W-1:0] round,
    output logic               busy,
    output logic               win,
    output logic               error
);

    localparam int unsigned MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

`ifdef VERIF_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    verif_state_t       state, stateNext;
    logic [DIGIT_W-1:0] idx, idxNext;
    logic [DIGIT_W-1:0] roundNext;
    logic [DIGIT_W-1:0] showDigitNext;
    logic               showEnNext;
    logic               busyNext;
    logic               winNext;
    logic               errorNext;
    logic               tmrLd;
    logic [TMR_W-1:0]   tmrVal;
    logic               tmrCero;
    logic               acierto;
    logic               abort;
    logic               ultimoIdx;

    temporizador #(
        .ANCHO(TMR_W)
    ) uTemporizador (
        .clock(clock),
        .reset(reset),
        .ld   (tmrLd),
        .val  (tmrVal),
        .cero (tmrCero)
    );

    // The store address is only meaningful while showing or checking.
    assign readAdd = ((state == SHOW) || (state == INPUT)) ? idx : '0;

    assign acierto   = esDigito(key) && (key == outMem);
    assign ultimoIdx = ((idx + DIGIT_W'(1)) >= round);
    // Losing memReady mid-game means the generator restarted underneath us.
    assign abort     = !memReady && ((state == SHOW) || (state == GAP) || (state == INPUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            round     <= '0;
            showDigit <= '0;
            showEn    <= 1'b0;
            busy      <= 1'b0;
            win       <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= stateNext;
            idx       <= idxNext;
            round     <= roundNext;
            showDigit <= showDigitNext;
            showEn    <= showEnNext;
            busy      <= busyNext;
            win       <= winNext;
            error     <= errorNext;
        end
    end

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        roundNext     = round;
        showDigitNext = showDigit;
        showEnNext    = 1'b0;
        winNext       = win;
        errorNext     = error;
        tmrLd         = 1'b0;
        tmrVal        = '0;

        case (state)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    stateNext = WAIT_MEM;
                    idxNext   = '0;
                    roundNext = '0;
                    winNext   = 1'b0;
                    errorNext = 1'b0;
                end
            end

            WAIT_MEM: begin
                if (memReady) begin
                    stateNext = SHOW;
                    roundNext = DIGIT_W'(1);
                    idxNext   = '0;
                    tmrLd     = 1'b1;
                    tmrVal    = TMR_W'(SHOW_CYCLES - 1);
                end
            end

            // Display register captures the read digit, so the display trails the state by one cycle.
            SHOW: begin
                showEnNext    = 1'b1;
                showDigitNext = outMem;
                if (tmrCero) begin
                    stateNext = GAP;
                    tmrLd     = 1'b1;
                    tmrVal    = TMR_W'(GAP_CYCLES - 1);
                end
            end

            GAP: begin
                if (tmrCero) begin
                    if (!ultimoIdx) begin
                        idxNext   = idx + DIGIT_W'(1);
                        stateNext = SHOW;
                        tmrLd     = 1'b1;
                        tmrVal    = TMR_W'(SHOW_CYCLES - 1);
                    end else begin
                        idxNext   = '0;
                        stateNext = INPUT;
                        tmrLd     = TIMEOUT_ON;
                        tmrVal    = TMR_W'(TIMEOUT_CYCLES - 1);
                    end
                end
            end

            INPUT: begin
                if (keyValid) begin
                    if (!acierto) begin
                        stateNext = LOSE;
                        errorNext = 1'b1;
                    end else if (!ultimoIdx) begin
                        idxNext = idx + DIGIT_W'(1);
                        tmrLd   = TIMEOUT_ON;
                        tmrVal  = TMR_W'(TIMEOUT_CYCLES - 1);
                    end else if (round == DIGIT_W'(N_DIGITS)) begin
                        stateNext = WIN;
                        winNext   = 1'b1;
                    end else begin
                        roundNext = round + DIGIT_W'(1);
                        idxNext   = '0;
                        stateNext = SHOW;
                        tmrLd     = 1'b1;
                        tmrVal    = TMR_W'(SHOW_CYCLES - 1);
                    end
                end else if (TIMEOUT_ON && tmrCero) begin
                    stateNext = LOSE;
                    errorNext = 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        if (abort) begin
            stateNext     = IDLE;
            idxNext       = '0;
            roundNext     = '0;
            showDigitNext = '0;
            showEnNext    = 1'b0;
            winNext       = 1'b0;
            errorNext     = 1'b0;
        end

        busyNext = !((stateNext == IDLE) || (stateNext == WIN) || (stateNext == LOSE));
    end

endmodule
